// File: rtl/nileswan_spi_pkg.sv
// nileswan_spi_pkg: shared types and constants for the SPI shift engine.
package nileswan_spi_pkg;

   localparam int BUF_AW_DEF = 9;
   localparam int DIV_W_DEF  = 4;

   localparam logic [1:0] MODE_TX   = 2'b00;
   localparam logic [1:0] MODE_RX   = 2'b01;
   localparam logic [1:0] MODE_XCHG = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_STORE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter for the serial clock; restarts low
// whenever run drops and is forced low by clr.
module spi_clk_div #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             level,
   output logic             rise,
   output logic             fall
);

   logic [DIV_W-1:0] cnt;
   logic             wrap;

   assign wrap = run && (cnt == div);
   assign rise = wrap && !level;
   assign fall = wrap && level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (clr || !run) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (cnt == div) begin
         cnt   <= '0;
         level <= ~level;
      end else begin
         cnt   <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: FastClk-domain byte shifter between the TX/RX buffers
// and the flash / TF serial ports (SPI mode 0, MSB first).
module spi_shift_engine
   import nileswan_spi_pkg::*;
#(
   parameter int BUF_AW = BUF_AW_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic              FastClk,
   input  logic              nReset,
   input  logic              Start,
   input  logic              Abort,
   input  logic [BUF_AW-1:0] Len,
   input  logic [1:0]        Mode,
   input  logic              DevSel,
   input  logic [DIV_W-1:0]  ClkDiv,
   output logic [BUF_AW-1:0] TxAddr,
   input  logic [7:0]        TxData,
   output logic [BUF_AW-1:0] RxAddr,
   output logic [7:0]        RxData,
   output logic              RxWe,
   output logic              Busy,
   output logic              Done,
   output logic              SPI_Clk,
   output logic              SPI_Do,
   input  logic              SPI_Di,
   output logic              TF_Clk,
   output logic              TF_Do,
   input  logic              TF_Di
);

   state_t            state;
   logic [BUF_AW-1:0] len_q;
   logic [BUF_AW-1:0] idx;
   logic [1:0]        mode_q;
   logic              dev_q;
   logic [DIV_W-1:0]  div_q;
   logic [7:0]        sh;
   logic [7:0]        rx;
   logic [7:0]        ld;
   logic [2:0]        nbit;
   logic              first;
   logic              sclk;
   logic              rise;
   logic              fall;
   logic              di;
   logic              do_bit;
   logic              tx_only;
   logic              rx_only;
   logic              run;

   assign tx_only = (mode_q == MODE_TX);
   assign rx_only = (mode_q == MODE_RX);
   assign ld      = rx_only ? 8'hFF : TxData;
   assign di      = dev_q ? TF_Di : SPI_Di;
   assign run     = (state == ST_SHIFT);

   // first SHIFT cycle shows bit 7 straight from the buffer read port,
   // so it is set up before the first rising edge even at H=1
   assign do_bit  = !run ? 1'b1 : (first ? ld[7] : sh[7]);

   assign SPI_Clk = sclk & ~dev_q;
   assign SPI_Do  = do_bit | dev_q;
   assign TF_Clk  = sclk & dev_q;
   assign TF_Do   = do_bit | ~dev_q;

   spi_clk_div #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk   (FastClk),
      .rst_n (nReset),
      .run   (run),
      .clr   (Abort),
      .div   (div_q),
      .level (sclk),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge FastClk or negedge nReset) begin
      if (!nReset) begin
         state  <= ST_IDLE;
         len_q  <= '0;
         idx    <= '0;
         mode_q <= MODE_TX;
         dev_q  <= 1'b0;
         div_q  <= '0;
         sh     <= 8'hFF;
         rx     <= 8'h00;
         nbit   <= 3'd0;
         first  <= 1'b0;
         TxAddr <= '0;
         RxAddr <= '0;
         RxData <= 8'h00;
         RxWe   <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         RxWe <= 1'b0;
         Done <= 1'b0;
         if (Abort) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            first <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (Start) begin
                     len_q  <= Len;
                     mode_q <= Mode;
                     dev_q  <= DevSel;
                     div_q  <= ClkDiv;
                     idx    <= '0;
                     TxAddr <= '0;
                     Busy   <= 1'b1;
                     state  <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  first <= 1'b1;
                  nbit  <= 3'd0;
                  state <= ST_SHIFT;
               end
               ST_SHIFT: begin
                  first <= 1'b0;
                  if (first)
                     sh <= ld;
                  if (rise)
                     rx <= {rx[6:0], di};
                  if (fall) begin
                     sh   <= {sh[6:0], 1'b1};
                     nbit <= nbit + 3'd1;
                     if (nbit == 3'd7) begin
                        state <= ST_STORE;
                        if (!tx_only) begin
                           RxWe   <= 1'b1;
                           RxAddr <= idx;
                           RxData <= rx;
                        end
                     end
                  end
               end
               ST_STORE: begin
                  if (idx == len_q) begin
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     idx    <= idx + BUF_AW'(1);
                     TxAddr <= idx + BUF_AW'(1);
                     state  <= ST_FETCH;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- FastClk-domain serial engine that sits directly below the SPI register/buffer stage.
- On a start command it fetches bytes from the TX buffer and shifts them MSB-first on the selected port (SPI flash or TF card, SPI mode 0).
- It samples the returning bits and writes each received byte into the RX buffer.
- Chip selects, power and the register interface stay in the stage above. This block owns only clocking, shifting and buffer addressing.

Parameters:
- BUF_AW, 9, buffer address width (512-byte TX/RX buffers)
- DIV_W, 4, width of the clock-divider field

Ports:
- FastClk  in  1  engine clock
- nReset  in  1  asynchronous active-low reset
- Start  in  1  one-cycle start pulse, already synchronised to FastClk
- Abort  in  1  one-cycle abort pulse
- Len  in  BUF_AW  byte count minus 1 (0..511 gives 1..512 bytes)
- Mode  in  2  00 TX-only, 01 RX-only, 10 exchange, 11 treated as exchange
- DevSel  in  1  0 = flash port, 1 = TF port
- ClkDiv  in  DIV_W  half-period of the serial clock = ClkDiv+1 FastClk cycles
- TxAddr  out  BUF_AW  TX buffer read address
- TxData  in  8  TX buffer read data, valid 1 cycle after TxAddr
- RxAddr  out  BUF_AW  RX buffer write address
- RxData  out  8  RX buffer write data
- RxWe  out  1  RX buffer write strobe, one cycle per byte
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle completion pulse
- SPI_Clk, SPI_Do  out  1  flash port clock and data out
- SPI_Di  in  1  flash port data in
- TF_Clk, TF_Do  out  1  TF port clock and data out
- TF_Di  in  1  TF port data in

Behaviour:
- Reset values (asserted asynchronously, immediately, also mid-transfer):
  - Busy=0, Done=0, RxWe=0, TxAddr=0, RxAddr=0, RxData=0
  - both Clk=0, both Do=1
  - state IDLE
- Idle port levels: clock low, Do high. The non-selected port always shows idle levels.
- Start accepted only in IDLE. At acceptance, Len, Mode, DevSel and ClkDiv are captured; later changes are ignored until the next Start.
- Start while Busy is ignored.
- Start and Abort in the same IDLE cycle: Abort wins, nothing starts.
- Notation: H = ClkDiv+1; byte index i counts 0..Len.
- FSM:
  - IDLE: Start -> FETCH. Busy goes high the cycle after Start.
  - FETCH (1 cycle): drive TxAddr=i -> SHIFT.
  - SHIFT:
    - On the first cycle, load the shifter from TxData (0xFF in RX-only mode) and drive Do=bit7.
    - Each bit is H cycles clock-low, then H cycles clock-high.
    - Di is sampled on the low->high transition cycle.
    - Do advances to the next bit on the high->low transition.
    - After the 8th high phase the clock returns low -> STORE.
  - STORE (1 cycle):
    - If Mode is not TX-only: RxWe=1, RxAddr=i, RxData=received byte.
    - If i==Len -> DONE, else i+1 and -> FETCH.
  - DONE: Done=1 and Busy=0 in the same cycle -> IDLE.
- Timing:
  - Per byte: 16H+2 cycles.
  - Busy is high for exactly N*(16H+2) cycles, where N = Len+1.
  - TX-only mode still spends the STORE cycle, so timing is mode-independent.
- Do is constant 1 in RX-only mode. RX data is discarded in TX-only mode.
- i never wraps: Len=511 ends after index 511.
- Abort in any non-IDLE state:
  - next cycle IDLE, Busy=0, Clk=0, Do=1
  - no Done, no further RxWe
  - a partial byte is not written

Decomposition:
- Shared package nileswan_spi_pkg holds:
  - state enum (IDLE, FETCH, SHIFT, STORE, DONE)
  - Mode constants (MODE_TX, MODE_RX, MODE_XCHG)
  - BUF_AW default
- One sub-module, spi_clk_div: half-period counter that produces rise/fall strobes and the clock level, restartable per byte and cleared on abort.

Test Plan:
- Reset during SHIFT at ClkDiv=5 -> outputs at reset values in the same cycle; SPI_Clk=0, Do=1, Busy=0.
- Exchange, flash port, ClkDiv=0, Len=1, TX buffer [0xA5,0x3C], SPI_Do looped to SPI_Di -> RxWe at addr0=0xA5 and addr1=0x3C; Busy high exactly 36 cycles; one Done pulse; TF_Clk stays 0 and TF_Do stays 1.
- RX-only, TF port, ClkDiv=3, slave returns 0x81 -> TF_Do constant 1; TF_Clk period 8 cycles; RxData=0x81 at addr0.
- TX-only, Len=511 -> TxAddr steps 0..511 with no wrap; RxWe never asserted; Done after 512*18 cycles.
- Exchange Len=3, Abort during 3rd byte -> clock low next cycle; only 2 RxWe pulses; no Done; a following Start runs normally from index 0.
- Start asserted while Busy -> no effect on timing or data. Start and Abort together in IDLE -> Busy stays 0.
